// File: rtl/ahblite_dma_master.sv
// Word-copy DMA engine acting as an AHB-Lite initiator.
// It copies with single NONSEQ read/write pairs and pulses done (with err) when it finishes.
module ahblite_dma_master #(
   parameter int unsigned LEN_W     = 16,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [LEN_W-1:0] remaining,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic [3:0]       HPROT,
   output logic             HMASTLOCK,
   output logic [31:0]      HWDATA,
   input  logic [31:0]      HRDATA,
   input  logic             HREADY,
   input  logic             HRESP
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_FIN
   } state_t;

   state_t           state, state_nxt;
   logic [AW-1:0]    src, dst, src_nxt, dst_nxt, haddr_nxt;
   logic [DW-1:0]    data_buf, buf_nxt;
   logic [LEN_W-1:0] rem_nxt;
   logic [1:0]       htrans_nxt;
   logic             hwrite_nxt, busy_nxt, done_nxt, err_nxt;
   logic             unused_addr_lsbs;

   assign HSIZE     = 3'b010;
   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;
   assign HWDATA    = data_buf;
   assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

   // State register
   always_ff @(posedge HCLK) begin
      if (!HRESETn) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; only HREADY=1 edges advance bus phases
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (start) state_nxt = (len == '0) ? S_FIN : S_RD_ADDR;
         S_RD_ADDR: if (HREADY) state_nxt = S_RD_DATA;
         S_RD_DATA: if (HREADY) state_nxt = HRESP ? S_FIN : S_WR_ADDR;
         S_WR_ADDR: if (HREADY) state_nxt = S_WR_DATA;
         S_WR_DATA: begin
            if (HREADY) begin
               if (HRESP || remaining == LEN_W'(1)) state_nxt = S_FIN;
               else                                 state_nxt = S_RD_ADDR;
            end
         end
         S_FIN:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values; bus outputs are decoded from the next state so they leave flops
   always_comb begin
      src_nxt    = src;
      dst_nxt    = dst;
      rem_nxt    = remaining;
      buf_nxt    = data_buf;
      err_nxt    = err;
      haddr_nxt  = HADDR;
      hwrite_nxt = HWRITE;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               src_nxt = {src_addr[31:2], 2'b00};
               dst_nxt = {dst_addr[31:2], 2'b00};
               rem_nxt = len;
               err_nxt = 1'b0;
            end
         end
         S_RD_DATA: begin
            if (HREADY) begin
               if (HRESP) err_nxt = 1'b1;
               else       buf_nxt = HRDATA;
            end
         end
         S_WR_DATA: begin
            if (HREADY) begin
               if (HRESP) begin
                  err_nxt = 1'b1;
               end else begin
                  src_nxt = src + AW'(4);
                  dst_nxt = dst + AW'(4);
                  rem_nxt = remaining - LEN_W'(1);
               end
            end
         end
         default: ;
      endcase
      unique case (state_nxt)
         S_RD_ADDR: begin
            haddr_nxt  = src_nxt;
            hwrite_nxt = 1'b0;
         end
         S_WR_ADDR: begin
            haddr_nxt  = dst_nxt;
            hwrite_nxt = 1'b1;
         end
         default: ;
      endcase
      htrans_nxt = (state_nxt == S_RD_ADDR || state_nxt == S_WR_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
      busy_nxt   = (state_nxt != S_IDLE);
      done_nxt   = (state_nxt == S_FIN);
   end

   // Registered outputs and datapath
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         src       <= '0;
         dst       <= '0;
         data_buf  <= '0;
         remaining <= '0;
         err       <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         HADDR     <= '0;
         HWRITE    <= 1'b0;
         HTRANS    <= TRANS_IDLE;
      end else begin
         src       <= src_nxt;
         dst       <= dst_nxt;
         data_buf  <= buf_nxt;
         remaining <= rem_nxt;
         err       <= err_nxt;
         done      <= done_nxt;
         busy      <= busy_nxt;
         HADDR     <= haddr_nxt;
         HWRITE    <= hwrite_nxt;
         HTRANS    <= htrans_nxt;
      end
   end

endmodule

// File: tb/tb_ahblite_dma_master.sv
// Directed bench for ahblite_dma_master with a small AHB-Lite responder model.
module tb_ahblite_dma_master;

   logic        HCLK, HRESETn, start;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] len;
   logic        busy, done, err;
   logic [15:0] remaining;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;

   ahblite_dma_master dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
      .remaining(remaining), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Responder knobs, written only by the stimulus block
   int   ws;
   int   err_at;
   logic force_stall;
   logic [31:0] rmem [0:4095];

   // Responder state, written only by the responder process
   logic        dp_active, dp_write, dp_err;
   logic [31:0] dp_addr;
   int          dp_wait;
   int          rd_cnt, an, wn;
   logic [31:0] alog_addr [0:63];
   logic        alog_wr   [0:63];
   logic [31:0] wlog_addr [0:63];
   logic [31:0] wlog_data [0:63];

   assign HREADY = !force_stall && !(dp_active && dp_wait != 0);
   assign HRESP  = dp_active && dp_err;
   assign HRDATA = (dp_active && !dp_write) ? rmem[dp_addr[13:2]] : 32'hDEAD_BEEF;

   always @(posedge HCLK) begin
      if (!HRESETn) begin
         dp_active <= 1'b0;
         dp_err    <= 1'b0;
         dp_wait   <= 0;
      end else begin
         if (dp_active && dp_wait != 0) dp_wait <= dp_wait - 1;
         if (HREADY) begin
            if (dp_active && dp_write && !dp_err) begin
               wlog_addr[wn[5:0]] <= dp_addr;
               wlog_data[wn[5:0]] <= HWDATA;
               wn <= wn + 1;
            end
            dp_active <= 1'b0;
            dp_err    <= 1'b0;
            if (HTRANS == 2'b10) begin
               alog_addr[an[5:0]] <= HADDR;
               alog_wr[an[5:0]]   <= HWRITE;
               an        <= an + 1;
               dp_active <= 1'b1;
               dp_addr   <= HADDR;
               dp_write  <= HWRITE;
               if (!HWRITE && rd_cnt + 1 == err_at) begin
                  dp_err  <= 1'b1;
                  dp_wait <= 1;
               end else begin
                  dp_wait <= ws;
               end
               if (!HWRITE) rd_cnt <= rd_cnt + 1;
            end
         end
      end
   end

   // Completion pulses and write-data movement during stalled write data phases
   int          done_total, instab;
   logic        wd_seen;
   logic [31:0] wd_prev;
   initial begin
      rd_cnt = 0; an = 0; wn = 0; done_total = 0; instab = 0; wd_seen = 1'b0; wd_prev = '0;
      dp_addr = '0; dp_write = 1'b0;
   end
   always @(posedge HCLK) begin
      if (done === 1'b1) done_total <= done_total + 1;
      if (dp_active && dp_write) begin
         if (wd_seen && HWDATA !== wd_prev) instab <= instab + 1;
         wd_prev <= HWDATA;
         wd_seen <= 1'b1;
      end else begin
         wd_seen <= 1'b0;
      end
   end

   int n_cmp, n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pulse start for one cycle and wait for done; lat is the cycle index after the start edge
   task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                          output int lat, output logic e);
      @(negedge HCLK);
      src_addr = s; dst_addr = d; len = l; start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      lat = -1; e = 1'bx;
      for (int k = 1; k <= 300; k++) begin
         if (done === 1'b1) begin
            lat = k; e = err;
            break;
         end
         @(negedge HCLK);
      end
   endtask

   int          lat, a0, w0, d0, i0;
   logic        e;
   logic [31:0] exp_a [0:5];

   initial begin
      n_cmp = 0; n_err = 0;
      ws = 0; err_at = 0; force_stall = 1'b0;
      HRESETn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
      for (int i = 0; i < 4096; i++) rmem[i] = 32'h0;
      rmem[0]     = 32'h1111_1111; rmem[1]     = 32'h2222_2222; rmem[2] = 32'h3333_3333;
      rmem[12'hFFF] = 32'hAAAA_5555;
      rmem[12'h0C0] = 32'hC0DE_0001; rmem[12'h0C1] = 32'hC0DE_0002;
      rmem[12'h140] = 32'h5000_0001; rmem[12'h141] = 32'h5000_0002;
      rmem[12'h240] = 32'h9000_0001;

      // Reset state
      repeat (3) @(negedge HCLK);
      check("rst_htrans", 32'(HTRANS), 32'h0);
      check("rst_haddr", HADDR, 32'h0);
      check("rst_hwrite", 32'(HWRITE), 32'h0);
      check("rst_hwdata", HWDATA, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_remaining", 32'(remaining), 32'h0);
      check("const_ctrl", {21'h0, HSIZE, HBURST, HPROT, HMASTLOCK}, {21'h0, 3'b010, 3'b000, 4'b0011, 1'b0});
      HRESETn = 1'b1;

      // Zero-wait three-word copy
      a0 = an; w0 = wn; d0 = done_total;
      do_copy(32'h2000_0000, 32'h2000_0100, 16'd3, lat, e);
      check("zw_latency", 32'(lat), 32'd13);
      check("zw_err", 32'(e), 32'h0);
      check("zw_remaining", 32'(remaining), 32'h0);
      check("zw_busy_at_done", 32'(busy), 32'h1);
      repeat (4) @(negedge HCLK);
      check("zw_busy_after", 32'(busy), 32'h0);
      check("zw_done_count", 32'(done_total - d0), 32'd1);
      check("zw_nonseq_count", 32'(an - a0), 32'd6);
      exp_a[0] = 32'h2000_0000; exp_a[1] = 32'h2000_0100; exp_a[2] = 32'h2000_0004;
      exp_a[3] = 32'h2000_0104; exp_a[4] = 32'h2000_0008; exp_a[5] = 32'h2000_0108;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("zw_haddr%0d", i), alog_addr[a0 + i], exp_a[i]);
         check($sformatf("zw_hwrite%0d", i), 32'(alog_wr[a0 + i]), 32'(i % 2));
      end
      check("zw_wdata0", wlog_data[w0],     32'h1111_1111);
      check("zw_wdata1", wlog_data[w0 + 1], 32'h2222_2222);
      check("zw_wdata2", wlog_data[w0 + 2], 32'h3333_3333);

      // Same copy with two wait states per data phase
      ws = 2; w0 = wn; d0 = done_total; i0 = instab;
      do_copy(32'h2000_0000, 32'h2000_0100, 16'd3, lat, e);
      check("ws_latency", 32'(lat), 32'd25);
      check("ws_err", 32'(e), 32'h0);
      repeat (3) @(negedge HCLK);
      ws = 0;
      check("ws_write_count", 32'(wn - w0), 32'd3);
      check("ws_waddr2", wlog_addr[w0 + 2], 32'h2000_0108);
      check("ws_wdata0", wlog_data[w0],     32'h1111_1111);
      check("ws_wdata2", wlog_data[w0 + 2], 32'h3333_3333);
      check("ws_hwdata_stable", 32'(instab - i0), 32'd0);
      check("ws_done_count", 32'(done_total - d0), 32'd1);

      // Two-cycle ERROR on the second read of a four-word copy
      err_at = rd_cnt + 2; w0 = wn; d0 = done_total;
      do_copy(32'h0000_0300, 32'h0000_0400, 16'd4, lat, e);
      check("er_latency", 32'(lat), 32'd8);
      check("er_err", 32'(e), 32'h1);
      check("er_remaining", 32'(remaining), 32'd3);
      repeat (3) @(negedge HCLK);
      err_at = 0;
      check("er_write_count", 32'(wn - w0), 32'd1);
      check("er_waddr0", wlog_addr[w0], 32'h0000_0400);
      check("er_wdata0", wlog_data[w0], 32'hC0DE_0001);
      check("er_err_held", 32'(err), 32'h1);

      // Zero-length request: immediate completion, no bus activity, err cleared
      a0 = an; d0 = done_total;
      do_copy(32'h0000_0300, 32'h0000_0400, 16'd0, lat, e);
      check("z_latency", 32'(lat), 32'd1);
      check("z_err", 32'(e), 32'h0);
      check("z_remaining", 32'(remaining), 32'h0);
      repeat (3) @(negedge HCLK);
      check("z_nonseq_count", 32'(an - a0), 32'd0);
      check("z_done_count", 32'(done_total - d0), 32'd1);

      // Start pulsed again while busy is ignored
      a0 = an; w0 = wn;
      @(negedge HCLK);
      src_addr = 32'h0000_0500; dst_addr = 32'h0000_0600; len = 16'd2; start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      @(negedge HCLK);
      src_addr = 32'h0000_0700; dst_addr = 32'h0000_0800; len = 16'd5; start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      lat = -1;
      for (int k = 3; k <= 300; k++) begin
         if (done === 1'b1) begin
            lat = k;
            break;
         end
         @(negedge HCLK);
      end
      check("bz_latency", 32'(lat), 32'd9);
      repeat (3) @(negedge HCLK);
      check("bz_nonseq_count", 32'(an - a0), 32'd4);
      check("bz_waddr1", wlog_addr[w0 + 1], 32'h0000_0604);
      check("bz_wdata0", wlog_data[w0],     32'h5000_0001);
      check("bz_wdata1", wlog_data[w0 + 1], 32'h5000_0002);

      // Reset asserted during a stalled write address phase
      w0 = wn; d0 = done_total;
      @(negedge HCLK);
      src_addr = 32'h0000_0900; dst_addr = 32'h0000_0A00; len = 16'd1; start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 50; k++) begin
         if (HTRANS == 2'b10 && HWRITE === 1'b1) begin
            lat = k;
            break;
         end
         @(negedge HCLK);
      end
      check("rs_wr_addr_cycle", 32'(lat), 32'd3);
      force_stall = 1'b1;
      repeat (2) @(negedge HCLK);
      check("rs_haddr_hold", HADDR, 32'h0000_0A00);
      check("rs_hwrite_hold", 32'(HWRITE), 32'h1);
      check("rs_htrans_hold", 32'(HTRANS), 32'h2);
      HRESETn = 1'b0;
      @(negedge HCLK);
      check("rs_htrans", 32'(HTRANS), 32'h0);
      check("rs_busy", 32'(busy), 32'h0);
      HRESETn = 1'b1; force_stall = 1'b0;
      repeat (8) @(negedge HCLK);
      check("rs_no_done", 32'(done_total - d0), 32'd0);
      check("rs_no_write", 32'(wn - w0), 32'd0);

      // Address wrap with misaligned inputs
      a0 = an; w0 = wn;
      do_copy(32'hFFFF_FFFF, 32'h0000_1003, 16'd2, lat, e);
      check("wr_latency", 32'(lat), 32'd9);
      repeat (3) @(negedge HCLK);
      check("wr_raddr0", alog_addr[a0],     32'hFFFF_FFFC);
      check("wr_waddr0", alog_addr[a0 + 1], 32'h0000_1000);
      check("wr_raddr1", alog_addr[a0 + 2], 32'h0000_0000);
      check("wr_waddr1", alog_addr[a0 + 3], 32'h0000_1004);
      check("wr_wdata0", wlog_data[w0],     32'hAAAA_5555);
      check("wr_wdata1", wlog_data[w0 + 1], 32'h1111_1111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
